// File: rtl/crt_parser.sv
// Streaming C64 .CRT image parser: validates the file header, walks CHIP packets,
// writes each payload to SDRAM on an 8 KiB boundary and emits one bank descriptor per chip.
module crt_parser #(
  parameter logic [24:0] BASE_ADDR = 25'h0000000,
  parameter logic [20:0] MAX_BYTES = 21'h100000
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        cart_loading,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [24:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [15:0] cart_id,
  output logic [7:0]  cart_exrom,
  output logic [7:0]  cart_game,
  output logic [15:0] cart_bank_laddr,
  output logic [15:0] cart_bank_size,
  output logic [15:0] cart_bank_num,
  output logic [7:0]  cart_bank_type,
  output logic [24:0] cart_bank_raddr,
  output logic        cart_bank_wr,
  output logic        cart_attached,
  output logic        crt_error
);

  localparam int unsigned AW = 25;
  localparam logic [AW:0]   LIMIT     = (AW+1)'(BASE_ADDR) + (AW+1)'(MAX_BYTES);
  localparam logic [AW-1:0] BANK_MASK = AW'(25'h1FFF);

  typedef enum logic [2:0] {IDLE, HDR, CHDR, DATA, SKIP, ERROR} state_t;

  state_t        state;
  logic          loading_q;
  logic [31:0]   off;
  logic [31:0]   hdr_len;
  logic [31:0]   pkt_len;
  logic [31:0]   skip_cnt;
  logic [31:0]   chip_cnt;
  logic [15:0]   data_cnt;
  logic [AW-1:0] ptr;

  function automatic logic [7:0] hdr_sig(input logic [3:0] i);
    case (i)
      4'd0:    hdr_sig = 8'h43;
      4'd1:    hdr_sig = 8'h36;
      4'd2:    hdr_sig = 8'h34;
      4'd4:    hdr_sig = 8'h43;
      4'd5:    hdr_sig = 8'h41;
      4'd6:    hdr_sig = 8'h52;
      4'd7:    hdr_sig = 8'h54;
      4'd8:    hdr_sig = 8'h52;
      4'd9:    hdr_sig = 8'h49;
      4'd10:   hdr_sig = 8'h44;
      4'd11:   hdr_sig = 8'h47;
      4'd12:   hdr_sig = 8'h45;
      default: hdr_sig = 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] chip_sig(input logic [1:0] i);
    case (i)
      2'd0:    chip_sig = 8'h43;
      2'd1:    chip_sig = 8'h48;
      2'd2:    chip_sig = 8'h49;
      default: chip_sig = 8'h50;
    endcase
  endfunction

  logic          rise, fall, take, len_bad;
  logic [15:0]   size_full;
  logic [31:0]   excess;
  logic [AW-1:0] ptr_next, ptr_round;

  assign rise      = cart_loading & ~loading_q;
  assign fall      = ~cart_loading & loading_q;
  // A pending SDRAM write blocks further payload bytes; everything else streams.
  assign in_ready  = (state != IDLE) && !((state == DATA) && wr_req);
  assign take      = in_valid & in_ready;
  assign size_full = {cart_bank_size[7:0], in_data};
  assign excess    = pkt_len - 32'd16 - 32'(size_full);
  assign len_bad   = {1'b0, pkt_len} < (33'd16 + 33'(size_full));
  assign ptr_next  = ptr + AW'(1);
  assign ptr_round = (ptr_next + BANK_MASK) & ~BANK_MASK;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      loading_q       <= 1'b0;
      off             <= '0;
      hdr_len         <= '0;
      pkt_len         <= '0;
      skip_cnt        <= '0;
      chip_cnt        <= '0;
      data_cnt        <= '0;
      ptr             <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      wr_req          <= 1'b0;
      cart_id         <= '0;
      cart_exrom      <= '0;
      cart_game       <= '0;
      cart_bank_laddr <= '0;
      cart_bank_size  <= '0;
      cart_bank_num   <= '0;
      cart_bank_type  <= '0;
      cart_bank_raddr <= '0;
      cart_bank_wr    <= 1'b0;
      cart_attached   <= 1'b0;
      crt_error       <= 1'b0;
    end else begin
      loading_q    <= cart_loading;
      cart_bank_wr <= 1'b0;
      if (rise) begin
        state         <= HDR;
        off           <= '0;
        hdr_len       <= '0;
        ptr           <= BASE_ADDR;
        chip_cnt      <= '0;
        wr_req        <= 1'b0;
        cart_attached <= 1'b0;
        crt_error     <= 1'b0;
      end else if (fall && state != IDLE) begin
        // Only a stream that ends exactly on a packet boundary counts as clean.
        state  <= IDLE;
        wr_req <= 1'b0;
        if (state == CHDR && off == 32'd0 && chip_cnt != 32'd0) cart_attached <= 1'b1;
        else                                                   crt_error     <= 1'b1;
      end else begin
        case (state)
          HDR: if (take) begin
            off <= off + 32'd1;
            if (off < 32'd16 && in_data != hdr_sig(off[3:0])) state <= ERROR;
            case (off)
              32'h10, 32'h11, 32'h12, 32'h13: hdr_len <= {hdr_len[23:0], in_data};
              32'h16, 32'h17:                 cart_id <= {cart_id[7:0], in_data};
              32'h18:                         cart_exrom <= in_data;
              32'h19:                         cart_game  <= in_data;
              default: ;
            endcase
            if (off == 32'h3F) begin
              if (hdr_len < 32'h40) state <= ERROR;
              else if (hdr_len == 32'h40) begin
                state <= CHDR;
                off   <= '0;
              end
            end else if (off > 32'h3F && off == hdr_len - 32'd1) begin
              state <= CHDR;
              off   <= '0;
            end
          end
          CHDR: if (take) begin
            off <= off + 32'd1;
            if (off < 32'd4 && in_data != chip_sig(off[1:0])) state <= ERROR;
            case (off)
              32'd4, 32'd5, 32'd6, 32'd7: pkt_len <= {pkt_len[23:0], in_data};
              32'd9:                      cart_bank_type  <= in_data;
              32'd10, 32'd11:             cart_bank_num   <= {cart_bank_num[7:0], in_data};
              32'd12, 32'd13:             cart_bank_laddr <= {cart_bank_laddr[7:0], in_data};
              32'd14:                     cart_bank_size  <= size_full;
              32'd15: begin
                cart_bank_size  <= size_full;
                cart_bank_raddr <= ptr;
                off             <= '0;
                data_cnt        <= '0;
                skip_cnt        <= excess;
                if (len_bad) state <= ERROR;
                else begin
                  cart_bank_wr <= 1'b1;
                  chip_cnt     <= chip_cnt + 32'd1;
                  if (size_full != 16'd0) state <= DATA;
                  else if (excess != 32'd0) state <= SKIP;
                end
              end
              default: ;
            endcase
          end
          DATA: begin
            // The chip is left only once its last write has completed.
            if (wr_req) begin
              if (wr_ack) begin
                wr_req   <= 1'b0;
                data_cnt <= data_cnt + 16'd1;
                if (data_cnt + 16'd1 == cart_bank_size) begin
                  ptr   <= ptr_round;
                  state <= (skip_cnt != 32'd0) ? SKIP : CHDR;
                end else begin
                  ptr <= ptr_next;
                end
              end
            end else if (take) begin
              if ({1'b0, ptr} >= LIMIT) state <= ERROR;
              else begin
                wr_req  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= in_data;
              end
            end
          end
          SKIP: if (take) begin
            skip_cnt <= skip_cnt - 32'd1;
            if (skip_cnt == 32'd1) state <= CHDR;
          end
          ERROR:   crt_error <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crt_parser.sv
// Randomised scoreboard bench for crt_parser: a byte-level image model predicts
// SDRAM writes, bank descriptors and the final attach/error status.
module tb_crt_parser;

  localparam int BASE = 0;
  localparam int MAXB = 'h4800;

  logic        clk32 = 1'b0;
  logic        reset, cart_loading, in_valid, wr_ack;
  logic [7:0]  in_data;
  logic        in_ready, wr_req, cart_bank_wr, cart_attached, crt_error;
  logic [24:0] wr_addr, cart_bank_raddr;
  logic [7:0]  wr_data, cart_exrom, cart_game, cart_bank_type;
  logic [15:0] cart_id, cart_bank_laddr, cart_bank_size, cart_bank_num;

  crt_parser #(.BASE_ADDR(25'(BASE)), .MAX_BYTES(21'(MAXB))) dut (
    .clk32(clk32), .reset(reset), .cart_loading(cart_loading),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
    .cart_id(cart_id), .cart_exrom(cart_exrom), .cart_game(cart_game),
    .cart_bank_laddr(cart_bank_laddr), .cart_bank_size(cart_bank_size),
    .cart_bank_num(cart_bank_num), .cart_bank_type(cart_bank_type),
    .cart_bank_raddr(cart_bank_raddr), .cart_bank_wr(cart_bank_wr),
    .cart_attached(cart_attached), .crt_error(crt_error)
  );

  always #5 clk32 = ~clk32;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int raddr; int num; int laddr; int size; int typ; } desc_t;

  wr_t        exp_wr[$];
  desc_t      exp_desc[$];
  logic [7:0] img[$];
  int n_checks = 0, n_fail = 0;
  int ack_min = 0, ack_max = 0;
  bit gaps = 0;
  int exp_att, exp_err, id_valid, exp_id, exp_exrom, exp_game;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void put_be(input logic [31:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) img.push_back(8'(v >> (8 * k)));
  endfunction

  function automatic void add_hdr(input int hlen, input int id, input int ex, input int gm, input int bad);
    string s = "C64 CARTRIDGE   ";
    for (int k = 0; k < 16; k++) img.push_back(k == bad ? 8'h58 : 8'(s[k]));
    put_be(32'(hlen), 4);
    put_be(32'h0100, 2);
    put_be(32'(id), 2);
    img.push_back(8'(ex));
    img.push_back(8'(gm));
    while (img.size() < hlen || img.size() < 'h40) img.push_back(8'($urandom));
  endfunction

  function automatic void add_chip(input int plen, input int typ, input int num, input int laddr, input int size);
    put_be(32'h43484950, 4);
    put_be(32'(plen), 4);
    put_be(32'(typ), 2);
    put_be(32'(num), 2);
    put_be(32'(laddr), 2);
    put_be(32'(size), 2);
    for (int k = 16; k < plen; k++) img.push_back(8'($urandom));
  endfunction

  function automatic int be(input int at, input int nb);
    int v = 0;
    for (int k = 0; k < nb; k++) v = (v << 8) | int'(img[at + k]);
    return v;
  endfunction

  // Reference: walk the image as a file, recording what the mapper should see.
  function automatic void model();
    string s = "C64 CARTRIDGE   ";
    string c = "CHIP";
    int n = img.size();
    int p, hlen, plen, size, ptr, chips;
    exp_att = 0; exp_err = 1; id_valid = 0;
    for (int k = 0; k < 16 && k < n; k++) if (img[k] != 8'(s[k])) return;
    if (n >= 'h1A) begin
      id_valid = 1; exp_id = be('h16, 2); exp_exrom = int'(img['h18]); exp_game = int'(img['h19]);
    end
    if (n < 'h40) return;
    hlen = be('h10, 4);
    if (hlen < 'h40 || hlen > n) return;
    p = hlen; ptr = BASE; chips = 0;
    forever begin
      if (p == n) begin
        if (chips > 0) begin exp_att = 1; exp_err = 0; end
        return;
      end
      for (int k = 0; k < 4; k++) if (p + k < n && img[p + k] != 8'(c[k])) return;
      if (n - p < 16) return;
      plen = be(p + 4, 4);
      size = be(p + 14, 2);
      if (plen < 16 + size) return;
      exp_desc.push_back('{raddr: ptr, num: be(p + 10, 2), laddr: be(p + 12, 2), size: size, typ: int'(img[p + 9])});
      chips++;
      for (int i = 0; i < size; i++) begin
        if (p + 16 + i >= n) return;
        if (ptr + i >= BASE + MAXB) return;
        exp_wr.push_back('{addr: ptr + i, data: int'(img[p + 16 + i])});
      end
      if (size > 0) ptr = (ptr + size + 'h1FFF) & ~'h1FFF;
      if (p + plen > n) return;
      p += plen;
    end
  endfunction

  task automatic send_img();
    int t;
    cart_loading = 1'b1;
    @(posedge clk32); #1;
    for (int i = 0; i < img.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk32); #1;
      end
      in_valid = 1'b1;
      in_data  = img[i];
      t = 0;
      while (!in_ready && t < 100) begin @(posedge clk32); #1; t++; end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL in_ready_timeout: byte %0d in_ready=0, expected 1", i);
        break;
      end
      @(posedge clk32); #1;
    end
    in_valid = 1'b0;
    t = 0;
    while (wr_req && t < 100) begin @(posedge clk32); #1; t++; end
  endtask

  task automatic close_img(input bit chk_ready);
    if (chk_ready) check("in_ready_in_error", 32'(in_ready), 1);
    cart_loading = 1'b0;
    repeat (3) @(posedge clk32);
    #1;
    check("cart_attached", 32'(cart_attached), 32'(exp_att));
    check("crt_error", 32'(crt_error), 32'(exp_err));
    if (id_valid != 0) begin
      check("cart_id", 32'(cart_id), 32'(exp_id));
      check("cart_exrom", 32'(cart_exrom), 32'(exp_exrom));
      check("cart_game", 32'(cart_game), 32'(exp_game));
    end
    check("missing_writes", 32'(exp_wr.size()), 0);
    check("missing_descriptors", 32'(exp_desc.size()), 0);
    exp_wr.delete();
    exp_desc.delete();
    repeat (2) @(posedge clk32);
    #1;
  endtask

  task automatic run_img(input bit chk_ready);
    model();
    send_img();
    close_img(chk_ready);
  endtask

  // SDRAM write port: ack after a programmable delay (0 = same cycle as the request).
  initial begin
    int wait_c = -1;
    wr_ack = 1'b0;
    forever begin
      @(posedge clk32); #1;
      wr_ack = 1'b0;
      if (!wr_req) wait_c = -1;
      else begin
        if (wait_c < 0) wait_c = $urandom_range(ack_max, ack_min);
        if (wait_c == 0) begin wr_ack = 1'b1; wait_c = -1; end
        else wait_c--;
      end
    end
  end

  // Monitor: pop expected traffic whenever the DUT presents a write or descriptor.
  initial begin
    wr_t w;
    desc_t d;
    forever begin
      @(negedge clk32);
      if (!reset) begin
        if (wr_req && wr_ack) begin
          if (exp_wr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h, expected no write", wr_addr);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(w.addr));
            check("wr_data", 32'(wr_data), 32'(w.data));
            check("in_ready_while_pending", 32'(in_ready), 0);
          end
        end
        if (cart_bank_wr) begin
          if (exp_desc.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_descriptor: got raddr 0x%0h, expected none", cart_bank_raddr);
          end else begin
            d = exp_desc.pop_front();
            check("bank_raddr", 32'(cart_bank_raddr), 32'(d.raddr));
            check("bank_num", 32'(cart_bank_num), 32'(d.num));
            check("bank_laddr", 32'(cart_bank_laddr), 32'(d.laddr));
            check("bank_size", 32'(cart_bank_size), 32'(d.size));
            check("bank_type", 32'(cart_bank_type), 32'(d.typ));
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nch, size, ex, keep;
    reset = 1'b1; cart_loading = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk32);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wr_req", 32'(wr_req), 0);
    check("rst_cart_id", 32'(cart_id), 0);
    check("rst_attached", 32'(cart_attached), 0);
    check("rst_error", 32'(crt_error), 0);
    reset = 1'b0;
    @(posedge clk32); #1;

    // Minimal 8K image
    img.delete(); add_hdr('h40, 0, 0, 1, -1); add_chip('h2010, 0, 0, 'h8000, 'h2000);
    run_img(0);
    // Two 4 KiB chips, then an empty chip exposing the final pointer
    img.delete(); add_hdr('h40, 18, 0, 0, -1);
    add_chip('h1010, 0, 0, 'h8000, 'h1000); add_chip('h1010, 0, 1, 'hA000, 'h1000);
    add_chip('h10, 0, 2, 'h8000, 0);
    run_img(0);
    // Bad signature byte 3
    img.delete(); add_hdr('h40, 5, 1, 0, 3); add_chip('h20, 0, 0, 'h8000, 'h10);
    run_img(1);
    // Long header and padded packet
    img.delete(); add_hdr('h50, 7, 1, 1, -1);
    add_chip('h2020, 0, 0, 'h8000, 'h2000); add_chip('h30, 2, 1, 'hA000, 'h20);
    run_img(0);
    // Truncation after 100 payload bytes
    img.delete(); add_hdr('h40, 0, 0, 1, -1); add_chip('h2010, 0, 0, 'h8000, 'h2000);
    while (img.size() > 'h40 + 16 + 100) void'(img.pop_back());
    run_img(0);
    // Header length below 0x40
    img.delete(); add_hdr('h3F, 1, 0, 1, -1); add_chip('h20, 0, 0, 'h8000, 'h10);
    run_img(1);
    // Window overflow on the third chip
    img.delete(); add_hdr('h40, 3, 0, 0, -1);
    add_chip('h11, 0, 0, 'h8000, 1); add_chip('h11, 0, 1, 'h8000, 1); add_chip('h910, 0, 2, 'h8000, 'h900);
    run_img(1);

    // Slow write port
    ack_min = 5; ack_max = 5;
    img.delete(); add_hdr('h40, 0, 0, 1, -1); add_chip('h30, 0, 0, 'h8000, 'h20);
    run_img(0);
    // Reset mid-DATA
    img.delete(); add_hdr('h40, 'h20, 1, 1, -1); add_chip('h210, 0, 3, 'h8000, 'h200);
    while (img.size() > 'h40 + 16 + 50) void'(img.pop_back());
    model();
    send_img();
    check("drained_before_reset", 32'(exp_wr.size()), 0);
    reset = 1'b1;
    #2;
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_wr_addr", 32'(wr_addr), 0);
    check("mid_rst_wr_data", 32'(wr_data), 0);
    check("mid_rst_cart_id", 32'(cart_id), 0);
    check("mid_rst_exrom", 32'(cart_exrom), 0);
    check("mid_rst_game", 32'(cart_game), 0);
    check("mid_rst_bank_size", 32'(cart_bank_size), 0);
    check("mid_rst_bank_num", 32'(cart_bank_num), 0);
    check("mid_rst_bank_laddr", 32'(cart_bank_laddr), 0);
    exp_wr.delete(); exp_desc.delete();
    cart_loading = 1'b0;
    @(posedge clk32); #1;
    reset = 1'b0;
    @(posedge clk32); #1;

    // Random small images with idle gaps and variable ack latency
    ack_min = 0; ack_max = 3; gaps = 1;
    for (int it = 0; it < 8; it++) begin
      img.delete();
      add_hdr('h40 + $urandom_range(0, 4), $urandom_range(0, 60), $urandom_range(0, 1), $urandom_range(0, 1), -1);
      nch = $urandom_range(1, 3);
      for (int c = 0; c < nch; c++) begin
        size = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
        ex   = $urandom_range(0, 3);
        if (it == 3 && c == nch - 1 && size > 0) ex = -1;
        add_chip(16 + size + ex, $urandom_range(0, 3), c, $urandom_range(0, 1) ? 'h8000 : 'hA000, size);
      end
      if (it == 5) begin
        keep = $urandom_range(1, img.size() - 1);
        while (img.size() > keep) void'(img.pop_back());
      end
      run_img(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crt_parser.md
# crt_parser

Streaming parser for C64 `.CRT` cartridge images, the producer for the cartridge mapper's bank-descriptor interface. It consumes the image byte-by-byte during download and validates the 64-byte file header. It extracts hardware type and EXROM/GAME, walks every CHIP packet, writes each payload into SDRAM on an 8 KiB-aligned boundary, and pulses one bank descriptor per packet. It sits between the download path (`cart_loading`, byte stream) and the cartridge mapper / SDRAM write port.

## Interface

Parameters:
- `BASE_ADDR`, 25'h0000000: SDRAM byte address of the first chip payload (8 KiB aligned).
- `MAX_BYTES`, 21'h100000: payload window size; any payload byte at or above `BASE_ADDR+MAX_BYTES` is an error.

Ports:
- `clk32`  in  1: system clock.
- `reset`  in  1: reset. One clock; reset is asynchronous and active-high.
- `cart_loading`  in  1: level high for the whole download; a rising edge starts a parse, a falling edge ends it.
- `in_data`  in  8: image byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: a byte is accepted when `in_valid & in_ready`.
- `wr_addr`  out  25: SDRAM payload write address.
- `wr_data`  out  8: SDRAM payload write data.
- `wr_req`  out  1: held high until `wr_ack`.
- `wr_ack`  in  1: one-cycle write completion.
- `cart_id`  out  16: hardware type, header bytes 0x16–0x17, big-endian.
- `cart_exrom`  out  8: header byte 0x18.
- `cart_game`  out  8: header byte 0x19.
- `cart_bank_laddr`  out  16: chip load address.
- `cart_bank_size`  out  16: chip image size.
- `cart_bank_num`  out  16: chip bank number.
- `cart_bank_type`  out  8: chip type (low byte).
- `cart_bank_raddr`  out  25: SDRAM address of the chip's first payload byte.
- `cart_bank_wr`  out  1: one-cycle descriptor strobe.
- `cart_attached`  out  1: high after a clean parse.
- `crt_error`  out  1: sticky until the next parse starts.

## Operation

- **Reset:** all outputs are 0, `in_ready=0`, state IDLE.
- **IDLE:**
  - `in_ready=0`.
  - A rising edge of `cart_loading` clears `cart_attached`, `crt_error` and the chip count, sets the payload pointer to `BASE_ADDR`, and enters HDR.
- **HDR:**
  - Byte offset counter runs from 0.
  - Bytes 0–15 must equal "C64 CARTRIDGE   " (ASCII, three trailing spaces); a mismatch goes to ERROR.
  - Bytes 0x10–0x13 hold the header length, big-endian, 32 bits.
  - 0x16–0x17 go to `cart_id`, 0x18 to `cart_exrom`, 0x19 to `cart_game`.
  - At offset 0x40, a header length below 0x40 goes to ERROR. Otherwise bytes up to header length-1 are discarded, then the state moves to CHDR.
- **CHDR (16 bytes):**
  - Bytes 0–3 must be "CHIP"; a mismatch goes to ERROR.
  - Bytes 4–7: packet length (32-bit BE). Bytes 8–9: type (the low byte goes to `cart_bank_type`). Bytes 10–11: `cart_bank_num`. Bytes 12–13: `cart_bank_laddr`. Bytes 14–15: `cart_bank_size`. All fields are BE and update as their bytes arrive.
  - After byte 15:
    - `cart_bank_raddr` = pointer.
    - `cart_bank_wr` pulses, and the chip count increments.
    - If packet length < 16+size, go to ERROR.
    - If size=0, go to SKIP (or back to CHDR if there is no excess); otherwise go to DATA.
- **DATA:**
  - Each accepted byte is written to the pointer: `wr_req` is held until `wr_ack`, then the pointer increments.
  - After `size` bytes, any excess (packet length-16-size) goes to SKIP; otherwise return to CHDR.
  - At chip end the pointer rounds up to the next 8 KiB boundary: (p+0x1FFF) & ~0x1FFF.
- **SKIP:** discards exactly the excess bytes, then goes to CHDR.
- **Falling edge of `cart_loading`:**
  - In CHDR at offset 0 with chip count ≥1: `cart_attached=1`, go to IDLE.
  - Any other state except ERROR: `crt_error=1`, go to IDLE.
  - In ERROR: go to IDLE; `crt_error` stays 1.
- **ERROR:**
  - `crt_error=1`, `in_ready=1` so the source drains; all bytes are discarded.
  - No `wr_req` and no `cart_bank_wr` is issued.
- **Window overflow:** a payload byte whose address is ≥ `BASE_ADDR+MAX_BYTES` goes to ERROR before the write is issued.
- **Rising edge of `cart_loading` in any state:** restarts the parse as from IDLE; a pending `wr_req` is dropped.

## Timing

- `in_ready=1` in HDR/CHDR/SKIP/ERROR. In DATA it is 1 only while no write is pending, so it falls the cycle after a payload byte is accepted and returns the cycle after `wr_ack`.
- `wr_req`, `wr_addr` and `wr_data` are registered: they assert the cycle after acceptance and are stable until `wr_ack`. `wr_ack` in the same cycle as assertion is legal.
- Throughput is 1 byte/cycle outside DATA.
- `cart_bank_wr` is high exactly one cycle, the cycle after CHDR byte 15 is accepted. All descriptor fields are valid in that cycle and hold until the next CHDR byte 4.
- `cart_attached` and `crt_error` update one cycle after the falling edge of `cart_loading` is sampled.
- Counters are 32-bit and wrap-free; header and packet lengths up to 2^32-1 are accepted.

## Test plan

- **Minimal 8K image:** header length 0x40, `cart_id`=0, exrom=0, game=1, one CHIP with size 0x2000 and laddr 0x8000 -> `cart_id`=0, `cart_exrom`=0, `cart_game`=1; one `cart_bank_wr` with raddr=0x0000000; 8192 writes at 0x0000000–0x0001FFF; `cart_attached`=1, `crt_error`=0.
- **Two 4 KiB chips (type 18):** second chip raddr=0x0002000 (rounded up); pointer after the last chip is 0x0004000.
- **Bad signature:** byte 3 = 'X' -> `crt_error`=1; no `wr_req` and no `cart_bank_wr`; `in_ready` stays 1 until `cart_loading` falls.
- **Header length 0x50 and packet length 0x2020 with size 0x2000:** 16 header bytes and 16 trailing packet bytes are skipped; the next CHIP is parsed correctly.
- **Truncation mid-DATA:** `cart_loading` falls after 100 payload bytes -> `crt_error`=1, `cart_attached`=0.
- **`wr_ack` held off 5 cycles per byte:** `in_ready` is low for those cycles, no byte is lost, and addresses are sequential. Asserting `reset` mid-DATA -> all outputs 0 immediately.
